// File: rtl/frontend_bank_cmd_translator_if.sv
// Request/command bus between the frontend interconnect, the bank command translator
// and the downstream command scheduler.
interface frontend_bank_cmd_translator_if #(
  parameter int unsigned BANK_BITS = 3,
  parameter int unsigned ROW_BITS  = 14,
  parameter int unsigned COL_BITS  = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_op;
  logic                 in_data_type;
  logic [ROW_BITS-1:0]  in_row;
  logic [COL_BITS-1:0]  in_col;
  logic [BANK_BITS-1:0] in_bank;
  logic [4:0]           in_req_id;
  logic [1:0]           in_core_num;
  logic                 close_all;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_cmd;
  logic                 out_bl;
  logic [13:0]          out_row;
  logic [13:0]          out_col;
  logic [2:0]           out_bank;
  logic [4:0]           out_req_id;
  logic [1:0]           out_core_num;
  logic                 out_last;

  modport master (
    output in_valid, in_op, in_data_type, in_row, in_col, in_bank, in_req_id, in_core_num,
    output close_all, out_ready,
    input  in_ready, out_valid, out_cmd, out_bl, out_row, out_col, out_bank,
    input  out_req_id, out_core_num, out_last
  );

  modport slave (
    input  in_valid, in_op, in_data_type, in_row, in_col, in_bank, in_req_id, in_core_num,
    input  close_all, out_ready,
    output in_ready, out_valid, out_cmd, out_bl, out_row, out_col, out_bank,
    output out_req_id, out_core_num, out_last
  );
endinterface

// File: rtl/frontend_bank_cmd_translator.sv
// Expands one frontend request into PRECHARGE/ACTIVE/READ/WRITE using a per-bank open-row table.
// Define AUTO_PRECHARGE_EN for the closed-page policy (RDA/WRA, bank closed after each access).
module frontend_bank_cmd_translator #(
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned BANK_BITS = 3,
  parameter int unsigned ROW_BITS  = 14,
  parameter int unsigned COL_BITS  = 10,
  parameter int unsigned BURST_BL8 = 1
) (
  input logic clk,
  input logic rst,
  frontend_bank_cmd_translator_if.slave bus
);
  localparam int unsigned OUT_ADDR_BITS = 14;
  localparam int unsigned OUT_BANK_BITS = 3;

  typedef enum logic [3:0] {
    CMD_NOP       = 4'd0,
    CMD_READ      = 4'd1,
    CMD_WRITE     = 4'd2,
    CMD_ACTIVE    = 4'd6,
    CMD_PRECHARGE = 4'd7,
    CMD_WRA       = 4'd13,
    CMD_RDA       = 4'd14
  } command_t;

  typedef enum logic [1:0] {IDLE, PRE, ACT, RW} state_t;

  typedef struct packed {
    logic                 op;
    logic                 data_type;
    logic [ROW_BITS-1:0]  row;
    logic [COL_BITS-1:0]  col;
    logic [BANK_BITS-1:0] bank;
    logic [4:0]           req_id;
    logic [1:0]           core_num;
  } req_t;

  typedef struct packed {
    logic                     valid;
    command_t                 cmd;
    logic                     bl;
    logic [OUT_ADDR_BITS-1:0] row;
    logic [OUT_ADDR_BITS-1:0] col;
    logic [OUT_BANK_BITS-1:0] bank;
    logic [4:0]               req_id;
    logic [1:0]               core_num;
    logic                     last;
  } cmd_t;

  state_t               state_q, state_d;
  req_t                 req_q, in_req;
  cmd_t                 cmd_q, cmd_d;
  logic                 in_ready_q;
  logic [NUM_BANKS-1:0] open_q;
  logic [ROW_BITS-1:0]  row_tbl [NUM_BANKS];
  logic                 accept, hs, bank_open, row_hit;
  logic                 unused_data_type;

  // Command word for a given state; fields that carry no meaning stay zero.
  function automatic cmd_t build_cmd(input state_t st, input req_t r);
    cmd_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.bank     = OUT_BANK_BITS'(r.bank);
    c.req_id   = r.req_id;
    c.core_num = r.core_num;
    case (st)
      PRE: c.cmd = CMD_PRECHARGE;
      ACT: begin
        c.cmd = CMD_ACTIVE;
        c.row = OUT_ADDR_BITS'(r.row);
      end
      default: begin
`ifdef AUTO_PRECHARGE_EN
        c.cmd = r.op ? CMD_RDA : CMD_WRA;
`else
        c.cmd = r.op ? CMD_READ : CMD_WRITE;
`endif
        c.col  = OUT_ADDR_BITS'(r.col);
        c.bl   = 1'(BURST_BL8);
        c.last = 1'b1;
      end
    endcase
    return c;
  endfunction

  assign in_req = '{op: bus.in_op, data_type: bus.in_data_type, row: bus.in_row,
                    col: bus.in_col, bank: bus.in_bank, req_id: bus.in_req_id,
                    core_num: bus.in_core_num};

  assign accept    = bus.in_valid && in_ready_q;
  assign hs        = cmd_q.valid && bus.out_ready;
  // A simultaneous close_all makes the incoming request see its bank closed.
  assign bank_open = open_q[in_req.bank] && !bus.close_all;
  assign row_hit   = bank_open && (row_tbl[in_req.bank] == in_req.row);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: if (accept) begin
        if (row_hit)        state_d = RW;
        else if (bank_open) state_d = PRE;
        else                state_d = ACT;
        cmd_d = build_cmd(state_d, in_req);
      end
      PRE: if (hs) begin
        state_d = ACT;
        cmd_d   = build_cmd(ACT, req_q);
      end
      ACT: if (hs) begin
        state_d = RW;
        cmd_d   = build_cmd(RW, req_q);
      end
      RW: if (hs) begin
        state_d = IDLE;
        cmd_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cmd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      in_ready_q <= (state_d == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) req_q <= in_req;
  end

  // Open-flag updates; close_all is applied last so it overrides an ACTIVE handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= '0;
    end else begin
      if (hs) begin
        case (state_q)
          PRE:     open_q[req_q.bank] <= 1'b0;
          ACT:     open_q[req_q.bank] <= 1'b1;
`ifdef AUTO_PRECHARGE_EN
          RW:      open_q[req_q.bank] <= 1'b0;
`endif
          default: ;
        endcase
      end
      if (bus.close_all) open_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (hs && state_q == ACT) row_tbl[req_q.bank] <= req_q.row;
  end

  assign unused_data_type = req_q.data_type;

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = cmd_q.valid;
  assign bus.out_cmd      = cmd_q.cmd;
  assign bus.out_bl       = cmd_q.bl;
  assign bus.out_row      = cmd_q.row;
  assign bus.out_col      = cmd_q.col;
  assign bus.out_bank     = cmd_q.bank;
  assign bus.out_req_id   = cmd_q.req_id;
  assign bus.out_core_num = cmd_q.core_num;
  assign bus.out_last     = cmd_q.last;
endmodule
